// File: rtl/instr_fetch_buf_if.sv
// Fetch-buffer bus: program RAM read port plus the instruction valid/ready stream.
interface instr_fetch_buf_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
);
  logic              ram_read_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic              instr_vld;
  logic              instr_rdy;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output ram_read_en, ram_addr, instr_vld, instr, instr_pc,
    input  ram_dout, instr_rdy
  );

  modport slave (
    input  ram_read_en, ram_addr, instr_vld, instr, instr_pc,
    output ram_dout, instr_rdy
  );
endinterface

// File: rtl/instr_fetch_buf.sv
// Instruction fetch front end: PC generation, prefetch FIFO, redirect flush, halt detection.
// Optional accepted-instruction counter enabled by FETCH_STATS_EN.
module instr_fetch_buf #(
  parameter int unsigned       DATA_W  = 16,
  parameter int unsigned       ADDR_W  = 10,
  parameter int unsigned       DEPTH   = 4,
  parameter logic [DATA_W-1:0] HALT_OP = 16'h3C00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_fetch_buf_if.master bus,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic [31:0]       fetch_cnt
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];

  logic              vld, pop, push, redir, start_ok, halt_hit, issue, flush;
  logic [CNT_W-1:0]  pending;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_pc;

  assign head_data = mem_data[rd_ptr_q];
  assign head_pc   = mem_pc[rd_ptr_q];

  assign vld      = (count_q != '0) && (state_q != S_HALT);
  assign pop      = vld && bus.instr_rdy;
  assign redir    = redirect && ((state_q == S_FETCH) || (state_q == S_DRAIN));
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign flush    = redir || start_ok;
  assign push     = inflight_q && !redir;
  assign halt_hit = push && (state_q == S_FETCH) && (bus.ram_dout == HALT_OP);

  // Entries left after this cycle's pop plus the word returning now must leave room.
  assign pending = count_q - CNT_W'(pop) + CNT_W'(inflight_q);
  assign issue   = (state_q == S_FETCH) && !redir && !halt_hit && (pending < CNT_W'(DEPTH));

  assign bus.ram_read_en = issue;
  assign bus.ram_addr    = pc_q;
  assign bus.instr_vld   = vld;
  assign bus.instr       = vld ? head_data : '0;
  assign bus.instr_pc    = vld ? head_pc : '0;
  assign halted          = (state_q == S_HALT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (redir) begin
          pc_d = redirect_pc;
        end else begin
          if (halt_hit) state_d = S_DRAIN;
          if (issue)    pc_d    = pc_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (redir) begin
          state_d = S_FETCH;
          pc_d    = redirect_pc;
        end else if (pop && (head_data == HALT_OP)) begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= issue;
      inflight_pc_q <= pc_q;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: instr/instr_pc are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= bus.ram_dout;
      mem_pc[wr_ptr_q]   <= inflight_pc_q;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
    end else if (start_ok) begin
      fetch_cnt_q <= '0;
    end else if (pop && (fetch_cnt_q != '1)) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
`else
  assign fetch_cnt = '0;
`endif
endmodule
